// File: rtl/stopwatch_control.sv
// Stopwatch front-panel controller: two debounced pushbuttons drive a four-state run/pause/lap FSM
// that gates the datapath count, pulses its clear and selects a frozen lap value for display.
module stopwatch_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EPOCH_W         = 28
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_start,
  input  logic               key_lap,
  input  logic [EPOCH_W-1:0] epoch,
  output logic               run,
  output logic               clear,
  output logic [EPOCH_W-1:0] display,
  output logic               lap_active,
  output logic [1:0]         state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRunning = 2'b01,
    StPaused  = 2'b10,
    StLap     = 2'b11
  } state_e;

  // Bit 0 carries the start key, bit 1 the lap key.
  logic [1:0]      keys_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_dly_q;
  logic [CntW-1:0] cnt_q [2];
  logic [1:0]      press;

  assign keys_raw = {key_lap, key_start};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;
      deb_dly_q <= 2'b11;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CntMax) begin
          deb_q[k] <= sync2_q[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  // High for the single cycle after a debounced 1->0 edge; releases and holds give nothing.
  assign press = deb_dly_q & ~deb_q;

  state_e             state_q;
  logic [EPOCH_W-1:0] lap_q;
  logic               clear_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lap_q   <= '0;
      clear_q <= 1'b1;
    end else begin
      clear_q <= 1'b0;
      // Start wins over a simultaneous lap event; the lap event is dropped.
      if (press[0]) begin
        unique case (state_q)
          StIdle:    state_q <= StRunning;
          StRunning: state_q <= StPaused;
          StPaused:  state_q <= StRunning;
          StLap:     state_q <= StPaused;
        endcase
      end else if (press[1]) begin
        unique case (state_q)
          StIdle: ;
          StRunning: begin
            state_q <= StLap;
            lap_q   <= epoch;
          end
          StLap:     state_q <= StRunning;
          StPaused: begin
            state_q <= StIdle;
            clear_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign state      = state_q;
  assign clear      = clear_q;
  assign run        = (state_q == StRunning) || (state_q == StLap);
  assign lap_active = (state_q == StLap);
  assign display    = (state_q == StLap) ? lap_q : epoch;

endmodule

// File: tb/tb_stopwatch_control.sv
// Randomized bench for stopwatch_control: a per-edge reference model queues expected outputs and a
// negedge monitor compares them against the DUT.
module tb_stopwatch_control;

  localparam int unsigned DB = 4;
  localparam int unsigned EW = 28;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PAUS = 2'b10;
  localparam logic [1:0] S_LAP  = 2'b11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          key_start = 1'b1;
  logic          key_lap = 1'b1;
  logic [EW-1:0] epoch = '0;
  logic          run, clear, lap_active;
  logic [EW-1:0] display;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  bit epoch_rand = 1'b1;

  stopwatch_control #(
    .DEBOUNCE_CYCLES(DB),
    .EPOCH_W        (EW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_start (key_start),
    .key_lap   (key_lap),
    .epoch     (epoch),
    .run       (run),
    .clear     (clear),
    .display   (display),
    .lap_active(lap_active),
    .state     (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    st;
    logic          clr;
    logic [EW-1:0] lap;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: key k is index 0 = start, 1 = lap.
  logic [1:0]    m_state;
  logic          m_clear;
  logic [EW-1:0] m_lap;
  bit            m_h1[2], m_h2[2], m_deb[2], m_pend[2];
  int            m_len[2];

  task automatic model_step();
    bit raw[2];
    bit d;
    bit st_ev, lp_ev;
    exp_t e;
    if (reset) begin
      m_state = S_IDLE;
      m_clear = 1'b1;
      m_lap   = '0;
      for (int k = 0; k < 2; k++) begin
        m_h1[k] = 1; m_h2[k] = 1; m_deb[k] = 1; m_pend[k] = 0; m_len[k] = 0;
      end
    end else begin
      st_ev   = m_pend[0];
      lp_ev   = m_pend[1];
      m_clear = 1'b0;
      if (st_ev) begin
        if (m_state == S_IDLE || m_state == S_PAUS) m_state = S_RUN;
        else m_state = S_PAUS;
      end else if (lp_ev) begin
        if (m_state == S_RUN) begin
          m_state = S_LAP;
          m_lap   = epoch;
        end else if (m_state == S_LAP) begin
          m_state = S_RUN;
        end else if (m_state == S_PAUS) begin
          m_state = S_IDLE;
          m_clear = 1'b1;
        end
      end
      raw[0] = key_start;
      raw[1] = key_lap;
      for (int k = 0; k < 2; k++) begin
        // Two synchronizer stages: the debouncer sees the level from two edges ago.
        d         = m_h2[k];
        m_h2[k]   = m_h1[k];
        m_h1[k]   = raw[k];
        m_pend[k] = 0;
        if (d != m_deb[k]) begin
          m_len[k]++;
          if (m_len[k] == DB) begin
            m_deb[k]  = d;
            m_len[k]  = 0;
            m_pend[k] = !d;
          end
        end else begin
          m_len[k] = 0;
        end
      end
    end
    e.st  = m_state;
    e.clr = m_clear;
    e.lap = m_lap;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got st=%b run=%b clr=%b lapact=%b disp=%h want st=%b run=%b clr=%b lapact=%b disp=%h",
               name, $time, got[32:31], got[30], got[29], got[28], got[27:0],
               want[32:31], want[30], want[29], want[28], want[27:0]);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  initial forever begin
    exp_t e;
    logic [EW-1:0] wdisp;
    @(negedge clock);
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      wdisp = (e.st == S_LAP) ? e.lap : epoch;
      check("outputs", {state, run, clear, lap_active, display},
            {e.st, (e.st == S_RUN) || (e.st == S_LAP), e.clr, e.st == S_LAP, wdisp});
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (epoch_rand) epoch = EW'($urandom());
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input bit which, input int hold);
    if (which) key_lap = 1'b0;
    else key_start = 1'b0;
    cycles(hold);
    key_start = 1'b1;
    key_lap   = 1'b1;
    cycles(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycles(3);
    @(negedge clock); #2 reset = 1'b0;
    cycles(4);
    // start / pause / resume
    press(0, 10);
    press(0, 10);
    press(0, 10);
    // lap freeze on a fixed epoch, then let epoch wander
    epoch_rand = 1'b0;
    epoch = 28'h0012345;
    cycles(2);
    press(1, 8);
    epoch_rand = 1'b1;
    cycles(20);
    press(1, 8);
    // pause then clear
    press(0, 8);
    press(1, 8);
    // bounce rejection
    for (int i = 0; i < 10; i++) begin
      key_start = ~key_start;
      cycles(2);
    end
    key_start = 1'b1;
    cycles(15);
    // simultaneous presses while running: start wins
    press(0, 8);
    key_start = 1'b0;
    key_lap   = 1'b0;
    cycles(8);
    key_start = 1'b1;
    key_lap   = 1'b1;
    cycles(12);
    // asynchronous reset mid-run, key held low through release
    press(0, 8);
    @(negedge clock); #2 reset = 1'b1;
    #1 check("async_reset", {state, run, clear, lap_active, display},
             {S_IDLE, 1'b0, 1'b1, 1'b0, epoch});
    cycles(1);
    key_start = 1'b0;
    cycles(2);
    @(negedge clock); #2 reset = 1'b0;
    cycles(20);
    key_start = 1'b1;
    cycles(12);
    // random key activity
    for (int i = 0; i < 150; i++) begin
      key_start = ($urandom_range(0, 3) != 0);
      key_lap   = ($urandom_range(0, 3) != 0);
      cycles($urandom_range(1, 10));
    end
    key_start = 1'b1;
    key_lap   = 1'b1;
    cycles(15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
